cordic_mult_approx_param: RTL and testbench

CORDIC_MULT_APPROX_PARAM -- requirements
Module: cordic_mult_approx_param

---
 rtl/cordic_approx_pkg.sv | 17 +
 rtl/approx_adder.sv | 33 +++
 rtl/cordic_mult_approx_param.sv | 148 ++++++++++++++
 tb/tb_cordic_mult_approx_param.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_approx_pkg.sv
// Shared types and constants for the CORDIC-style shift-add multiplier.
// The error-bound helper is used by the RTL assertions and by the bench.
package cordic_approx_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_CORR = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // Each approximate add is off by less than 2^(a+1); a W-bit multiply performs W+1 adds.
   function automatic int err_bound(input int w, input int a);
      return (w + 1) * (1 << (a + 1));
   endfunction

endpackage

// File: rtl/approx_adder.sv
// Adder whose low APPROX_BITS may be replaced by a carry-free OR, with a
// speculative carry into the exact upper part taken from the top approximate bit.
module approx_adder #(
   parameter int WIDTH       = 17,
   parameter int APPROX_BITS = 3
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             approx_en,
   output logic [WIDTH-1:0] sum
);

   logic [WIDTH-1:0] exact_sum;

   assign exact_sum = a + b;

   generate
      if (APPROX_BITS == 0) begin : g_exact
         assign sum = exact_sum;
      end else if (APPROX_BITS >= WIDTH) begin : g_all_or
         assign sum = approx_en ? (a | b) : exact_sum;
      end else begin : g_split
         localparam int UW = WIDTH - APPROX_BITS;
         logic          cin;
         logic [UW-1:0] upper;

         assign cin   = a[APPROX_BITS-1] & b[APPROX_BITS-1];
         assign upper = a[WIDTH-1:APPROX_BITS] + b[WIDTH-1:APPROX_BITS] + {{(UW-1){1'b0}}, cin};
         assign sum   = approx_en ? {upper, a[APPROX_BITS-1:0] | b[APPROX_BITS-1:0]} : exact_sum;
      end
   endgenerate

endmodule

// File: rtl/cordic_mult_approx_param.sv
// Sequential signed multiplier: non-restoring CORDIC-style decomposition of z into
// +/-2^i digits, one shift-add per cycle, plus a final residual correction step.
module cordic_mult_approx_param
   import cordic_approx_pkg::*;
#(
   parameter int W           = 8,
   parameter int APPROX_BITS = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   x,
   input  logic [W-1:0]   z,
   input  logic           approx_en,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] y,
   output logic           busy
);

   localparam int AW = 2 * W + 1;
   localparam int RW = W + 2;
   localparam int IW = $clog2(W);
   localparam logic signed [RW-1:0] R_ONE = RW'(1);

   state_e                state_q, state_d;
   logic [AW-1:0]         acc_q, acc_d;
   logic signed [RW-1:0]  r_q, r_d;
   logic [IW-1:0]         i_q, i_d;
   logic [W-1:0]          x_q, x_d;
   logic [W-1:0]          z_q, z_d;
   logic                  appr_q, appr_d;

   logic [AW-1:0]         x_ext;
   logic [AW-1:0]         x_shl;
   logic [AW-1:0]         addend;
   logic [AW-1:0]         acc_sum;
   logic signed [RW-1:0]  r_step;

   // The operand d*(x<<i) is built exactly before it reaches the (possibly inexact) adder.
   always_comb begin
      x_ext  = {{(AW-W){x_q[W-1]}}, x_q};
      x_shl  = x_ext << i_q;
      r_step = R_ONE << i_q;
      addend = '0;
      unique case (state_q)
         S_ITER:  addend = r_q[RW-1] ? -x_shl : x_shl;
         S_CORR: begin
            if (r_q == '0)     addend = '0;
            else if (r_q[RW-1]) addend = -x_ext;
            else                addend = x_ext;
         end
         default: addend = '0;
      endcase
   end

   approx_adder #(
      .WIDTH       (AW),
      .APPROX_BITS (APPROX_BITS)
   ) u_adder (
      .a         (acc_q),
      .b         (addend),
      .approx_en (appr_q),
      .sum       (acc_sum)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      r_d     = r_q;
      i_d     = i_q;
      x_d     = x_q;
      z_d     = z_q;
      appr_d  = appr_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               x_d     = x;
               z_d     = z;
               appr_d  = approx_en;
               acc_d   = '0;
               r_d     = {{2{z[W-1]}}, z};
               i_d     = IW'(W - 1);
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            acc_d = acc_sum;
            r_d   = r_q[RW-1] ? (r_q + r_step) : (r_q - r_step);
            if (i_q == '0) state_d = S_CORR;
            else           i_d     = i_q - IW'(1);
         end
         S_CORR: begin
            acc_d   = acc_sum;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         r_q     <= '0;
         i_q     <= '0;
         x_q     <= '0;
         z_q     <= '0;
         appr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         r_q     <= r_d;
         i_q     <= i_d;
         x_q     <= x_d;
         z_q     <= z_d;
         appr_q  <= appr_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign y         = acc_q[2*W-1:0];

   function automatic logic result_ok(input logic [AW-1:0] acc, input logic [W-1:0] xa,
                                      input logic [W-1:0] za, input logic ap);
      longint prod, got, diff;
      prod = longint'(signed'(xa)) * longint'(signed'(za));
      got  = longint'(signed'(acc[2*W-1:0]));
      diff = got - prod;
      if (diff < 0) diff = -diff;
      if (ap && (APPROX_BITS > 0)) return diff <= longint'(err_bound(W, APPROX_BITS));
      return diff == 0;
   endfunction

   // After the last digit the residual must have collapsed to one of -1, 0, +1.
   a_corr_residual: assert property (@(posedge clk) disable iff (rst)
      (state_q == S_CORR) |-> (r_q == '0 || r_q == R_ONE || r_q == -R_ONE));

   a_done_result: assert property (@(posedge clk) disable iff (rst)
      (state_q == S_DONE) |-> result_ok(acc_q, x_q, z_q, appr_q));

endmodule

// File: tb/tb_cordic_mult_approx_param.sv
// Self-checking bench for cordic_mult_approx_param (W=8, APPROX_BITS=3):
// exact and approximate products, latency, backpressure, mid-run reset, operand isolation.
module tb_cordic_mult_approx_param;
   import cordic_approx_pkg::*;

   localparam int W  = 8;
   localparam int A  = 3;
   localparam int AW = 2 * W + 1;
   localparam int TO = 40;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   x;
   logic [W-1:0]   z;
   logic           approx_en;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] y;
   logic           busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [2*W-1:0] exp_q[$];
   int             prod_q[$];

   cordic_mult_approx_param #(.W(W), .APPROX_BITS(A)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .z         (z),
      .approx_en (approx_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [AW-1:0] model_add(input logic [AW-1:0] a, input logic [AW-1:0] b, input bit ap);
      logic [AW-1:0] s;
      logic [AW-A-1:0] hi;
      if (!ap) return a + b;
      hi = a[AW-1:A] + b[AW-1:A] + {{(AW-A-1){1'b0}}, a[A-1] & b[A-1]};
      s  = {hi, a[A-1:0] | b[A-1:0]};
      return s;
   endfunction

   function automatic logic [2*W-1:0] model_mult(input int xv, input int zv, input bit ap);
      logic [AW-1:0] acc, xe, op;
      int r;
      acc = '0;
      xe  = AW'(xv);
      r   = zv;
      for (int i = W - 1; i >= 0; i--) begin
         op = xe << i;
         if (r < 0) begin
            op = -op;
            r  = r + (1 << i);
         end else begin
            r  = r - (1 << i);
         end
         acc = model_add(acc, op, ap);
      end
      if (r > 0)      op = xe;
      else if (r < 0) op = -xe;
      else            op = '0;
      acc = model_add(acc, op, ap);
      return acc[2*W-1:0];
   endfunction

   function automatic int rand_op();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic issue(input int xv, input int zv, input bit ap);
      int guard;
      guard     = 0;
      x         = W'(xv);
      z         = W'(zv);
      approx_en = ap;
      in_valid  = 1'b1;
      @(negedge clk);
      while (!in_ready && guard < TO) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      end
      exp_q.push_back(ap ? model_mult(xv, zv, 1'b1) : (2*W)'(xv * zv));
      prod_q.push_back(xv * zv);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      x         = W'($urandom);
      z         = W'($urandom);
      approx_en = 1'($urandom_range(0, 1));
   endtask

   // Waits for out_valid; completes the handshake when out_ready is high.
   task automatic collect(output logic [2*W-1:0] yv, output int edges);
      edges = 0;
      while (!out_valid && edges < TO) begin
         @(posedge clk); #1;
         edges++;
      end
      yv = y;
      if (out_valid && out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      n_cmp++; if (y !== '0)           begin n_err++; $display("FAIL reset_y: got %0h required 0", y); end
      n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
   endtask

   task automatic test_directed();
      int xs[3] = '{127, -128, -128};
      int zs[3] = '{127, -128, 127};
      logic [2*W-1:0] yv, e;
      int edges, p;
      for (int k = 0; k < 3; k++) begin
         issue(xs[k], zs[k], 1'b0);
         collect(yv, edges);
         e = exp_q.pop_front();
         p = prod_q.pop_front();
         n_cmp++;
         if (yv !== e) begin
            n_err++;
            $display("FAIL directed_y: x=%0d z=%0d got %0d required %0d", xs[k], zs[k], $signed(yv), p);
         end
         n_cmp++;
         if (edges != W + 1) begin
            n_err++;
            $display("FAIL directed_latency: got %0d edges required %0d", edges, W + 1);
         end
      end
   endtask

   task automatic test_sweep(input bit ap, input int n);
      int corner[5] = '{-128, -1, 0, 1, 127};
      logic [2*W-1:0] yv, e;
      int edges, p, xv, zv, diff;
      for (int k = 0; k < n; k++) begin
         if (k < 25) begin
            xv = corner[k / 5];
            zv = corner[k % 5];
         end else begin
            xv = rand_op();
            zv = rand_op();
         end
         issue(xv, zv, ap);
         collect(yv, edges);
         e = exp_q.pop_front();
         p = prod_q.pop_front();
         n_cmp++;
         if (yv !== e || edges != W + 1) begin
            n_err++;
            $display("FAIL sweep_y ap=%0d: x=%0d z=%0d got %0d after %0d edges required %0d after %0d",
                     ap, xv, zv, $signed(yv), edges, $signed(e), W + 1);
         end
         if (ap) begin
            diff = int'(signed'(yv)) - p;
            if (diff < 0) diff = -diff;
            n_cmp++;
            if (diff > err_bound(W, A)) begin
               n_err++;
               $display("FAIL approx_bound: x=%0d z=%0d error %0d required <= %0d", xv, zv, diff, err_bound(W, A));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [2*W-1:0] yv, e;
      int edges, p;
      out_ready = 1'b0;
      issue(-100, 57, 1'b0);
      collect(yv, edges);
      e = exp_q.pop_front();
      p = prod_q.pop_front();
      n_cmp++;
      if (yv !== e || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL bp_result: got %0d valid=%b required %0d valid=1", $signed(yv), out_valid, p);
      end
      for (int j = 0; j < 5; j++) begin
         if (j > 0) begin
            @(posedge clk); #1;
         end
         n_cmp++;
         if (y !== yv || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold cycle %0d: y=%0d valid=%b in_ready=%b required y=%0d valid=1 in_ready=0",
                     j + 1, $signed(y), out_valid, in_ready, $signed(yv));
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      n_cmp++;
      if (y !== yv || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL bp_cycle6: y=%0d valid=%b required y=%0d valid=1", $signed(y), out_valid, $signed(yv));
      end
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_release: in_ready=%b valid=%b required in_ready=1 valid=0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_iter();
      logic [2*W-1:0] yv, e;
      int edges, p;
      bit seen;
      issue(77, -99, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(exp_q.pop_back());
      void'(prod_q.pop_back());
      n_cmp++;
      if (out_valid !== 1'b0 || y !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL abort_state: valid=%b y=%0h busy=%b in_ready=%b required 0 0 0 1",
                  out_valid, y, busy, in_ready);
      end
      seen = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         seen = seen | out_valid;
      end
      n_cmp++;
      if (seen) begin
         n_err++;
         $display("FAIL abort_no_valid: out_valid seen=1 required 0");
      end
      issue(3, -5, 1'b0);
      collect(yv, edges);
      e = exp_q.pop_front();
      p = prod_q.pop_front();
      n_cmp++;
      if (yv !== e) begin
         n_err++;
         $display("FAIL post_abort_y: got %0d required %0d", $signed(yv), p);
      end
   endtask

   task automatic test_operand_isolation(input bit ap);
      logic [2*W-1:0] yv, e;
      int edges, p;
      issue(-93, 45, ap);
      x         = W'(-93);
      approx_en = ap;
      edges     = 0;
      while (!out_valid && edges < TO) begin
         @(posedge clk); #1;
         edges++;
         x         = ~x;
         approx_en = ~approx_en;
         z         = W'($urandom);
      end
      yv = y;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      p = prod_q.pop_front();
      n_cmp++;
      if (yv !== e || edges != W + 1) begin
         n_err++;
         $display("FAIL isolation ap=%0d: got %0d after %0d edges required %0d after %0d",
                  ap, $signed(yv), edges, $signed(e), W + 1);
      end
   endtask

   task automatic test_back_to_back();
      int xs[3] = '{-7, 100, -128};
      int zs[3] = '{9, -1, 1};
      int acc_cyc[3];
      logic [2*W-1:0] e;
      int guard, p;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         x         = W'(xs[k]);
         z         = W'(zs[k]);
         approx_en = 1'b0;
         guard     = 0;
         @(negedge clk);
         while (!in_ready && guard < TO) begin
            @(negedge clk);
            guard++;
         end
         acc_cyc[k] = cyc;
         exp_q.push_back((2*W)'(xs[k] * zs[k]));
         prod_q.push_back(xs[k] * zs[k]);
         @(posedge clk); #1;
         guard = 0;
         while (!out_valid && guard < TO) begin
            @(posedge clk); #1;
            guard++;
         end
         e = exp_q.pop_front();
         p = prod_q.pop_front();
         n_cmp++;
         if (y !== e || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_y op %0d: got %0d in_ready=%b required %0d in_ready=0", k, $signed(y), in_ready, p);
         end
         if (k > 0) begin
            n_cmp++;
            if (acc_cyc[k] - acc_cyc[k-1] < W + 2) begin
               n_err++;
               $display("FAIL b2b_interval: got %0d cycles required >= %0d", acc_cyc[k] - acc_cyc[k-1], W + 2);
            end
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   // ---------------- main sequence / report ----------------
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x         = '0;
      z         = '0;
      approx_en = 1'b0;
      test_reset();
      test_directed();
      test_sweep(1'b0, 700);
      test_sweep(1'b1, 700);
      test_backpressure();
      test_reset_mid_iter();
      test_operand_isolation(1'b0);
      test_operand_isolation(1'b1);
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
